// File: rtl/swipt_fsk_tx.sv
// FSK data transmitter for the SWIPT link: frames each byte as start, 8 data (LSB first),
// even parity and stop, and shifts the carrier word up (mark) or down (space) per bit.
module swipt_fsk_tx #(
    parameter int unsigned       FREQ_W     = 20,
    parameter int unsigned       BIT_CYCLES = 10000,
    parameter int unsigned       CNT_W      = 14,
    parameter logic [FREQ_W-1:0] RESET_FREQ = 20'h9C40
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              data_go,
    input  logic [FREQ_W-1:0] freq_base,
    input  logic [7:0]        freq_dev,
    input  logic [7:0]        tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [FREQ_W-1:0] freq,
    output logic              tx_busy,
    output logic              frame_done
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic [FREQ_W-1:0] base_q, base_d;
    logic [7:0]        dev_q, dev_d;
    logic [FREQ_W-1:0] freq_q, freq_d;

    logic              wrap;
    logic              accept;
    logic              bit_d;
    logic [FREQ_W-1:0] dev_ext;
    logic [FREQ_W:0]   mark_sum;
    logic [FREQ_W-1:0] mark_f;
    logic [FREQ_W-1:0] space_f;

    assign wrap       = (cnt_q == CNT_W'(BIT_CYCLES - 1));
    assign tx_ready   = (state_q == StIdle) && data_go && nrst;
    assign accept     = tx_valid && tx_ready;
    assign tx_busy    = (state_q != StIdle);
    assign frame_done = (state_q == StStop) && wrap;
    assign freq       = freq_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        base_d   = base_q;
        dev_d    = dev_q;
        if (state_q != StIdle) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StStart;
                    shift_d  = tx_data;
                    parity_d = ^tx_data;
                    base_d   = freq_base;
                    dev_d    = freq_dev;
                    cnt_d    = '0;
                    idx_d    = '0;
                end
            end
            StStart:  if (wrap) state_d = StData;
            StData: begin
                if (wrap) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = StParity;
                end
            end
            StParity: if (wrap) state_d = StStop;
            StStop:   if (wrap) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // The output word is registered, so it is computed from the state being entered.
    always_comb begin
        bit_d = 1'b0;
        case (state_d)
            StData:   bit_d = shift_d[0];
            StParity: bit_d = parity_d;
            StStop:   bit_d = 1'b1;
            default:  bit_d = 1'b0;
        endcase
        dev_ext  = {{(FREQ_W-8){1'b0}}, dev_d};
        mark_sum = {1'b0, base_d} + {1'b0, dev_ext};
        mark_f   = mark_sum[FREQ_W] ? '1 : mark_sum[FREQ_W-1:0];
        space_f  = (base_d < dev_ext) ? '0 : base_d - dev_ext;
        freq_d   = (state_d == StIdle) ? freq_base : (bit_d ? mark_f : space_f);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            base_q   <= '0;
            dev_q    <= '0;
            freq_q   <= RESET_FREQ;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            base_q   <= base_d;
            dev_q    <= dev_d;
            freq_q   <= freq_d;
        end
    end

endmodule

// File: tb/tb_swipt_fsk_tx.sv
// Bench for swipt_fsk_tx: table-driven frames, hand-written corner sequences and a
// randomized run, all checked every cycle against a frame-position reference model.
module tb_swipt_fsk_tx;
    localparam int unsigned BC = 4;
    localparam int unsigned FL = 11 * BC;
    localparam logic [19:0] RF = 20'h9C40;

    logic        clk = 1'b0;
    logic        nrst, data_go, tx_valid, tx_ready, tx_busy, frame_done;
    logic [19:0] freq_base, freq;
    logic [7:0]  freq_dev, tx_data;

    always #5 clk = ~clk;

    swipt_fsk_tx #(
        .FREQ_W    (20),
        .BIT_CYCLES(BC),
        .CNT_W     (2),
        .RESET_FREQ(RF)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .data_go   (data_go),
        .freq_base (freq_base),
        .freq_dev  (freq_dev),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .freq      (freq),
        .tx_busy   (tx_busy),
        .frame_done(frame_done)
    );

    typedef struct {
        logic [7:0]  b;
        logic [19:0] base;
        logic [7:0]  dev;
        logic [19:0] mark;
        logic [19:0] space;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    bit          chk_en = 0;
    // Model: position within the frame (0..FL-1) plus the latched mark/space words.
    bit          m_busy = 0;
    int          m_t = 0;
    logic [7:0]  m_byte = '0;
    logic [19:0] m_mark = '0, m_space = '0, m_freq = '0;
    logic [19:0] got [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit frame_bit(input logic [7:0] b, input int n);
        if (n == 0) return 1'b0;
        if (n <= 8) return b[n-1];
        if (n == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic logic [19:0] sat_add(input longint b, input longint d);
        return (b + d > 64'hFFFFF) ? 20'hFFFFF : 20'(b + d);
    endfunction

    function automatic logic [19:0] sat_sub(input longint b, input longint d);
        return (b < d) ? 20'd0 : 20'(b - d);
    endfunction

    // Check this cycle against the model, then advance the model across one clock edge.
    task automatic tick();
        bit          nb;
        int          nt;
        logic [19:0] nf;
        logic        r;
        #1;
        if (chk_en) begin
            chk("freq", freq, m_freq);
            chk("tx_busy", tx_busy, m_busy);
            chk("frame_done", frame_done, m_busy && (m_t == FL - 1));
            chk("tx_ready", tx_ready, !m_busy && data_go && nrst);
        end
        nb = m_busy; nt = m_t; nf = m_freq; r = nrst;
        if (!r) begin
            nb = 0; nt = 0; nf = RF;
        end else if (m_busy) begin
            if (m_t == FL - 1) begin
                nb = 0; nf = freq_base;
            end else begin
                nt = m_t + 1;
                nf = frame_bit(m_byte, nt / BC) ? m_mark : m_space;
            end
        end else if (tx_valid && data_go) begin
            m_byte  = tx_data;
            m_mark  = sat_add(freq_base, freq_dev);
            m_space = sat_sub(freq_base, freq_dev);
            nb = 1; nt = 0; nf = m_space;
        end else begin
            nf = freq_base;
        end
        @(posedge clk);
        #1;
        m_busy = nb; m_t = nt; m_freq = nf;
        if (!r) chk_en = 1;
    endtask

    task automatic run_frame(input logic [7:0] b, input bit hold, input int chg_at,
                             input int abort_at);
        bit stop = 0;
        tx_data  = b;
        tx_valid = 1;
        tick();
        chk("accept", tx_busy, 1);
        if (!hold) tx_valid = 0;
        for (int i = 0; i < FL && !stop; i++) begin
            #1;
            if (i % BC == 1) got[i / BC] = freq;
            if (i == FL - 2) chk("done_early", frame_done, 0);
            if (i == FL - 1) chk("done_last", frame_done, 1);
            if (i == chg_at) begin
                data_go   = 0;
                freq_base = 20'd30000;
            end
            if (i == abort_at) begin
                nrst = 0;
                stop = 1;
            end
            tick();
        end
        if (stop) nrst = 1;
    endtask

    initial begin
        vec_t vt [7];
        int   dcnt;
        vt[0] = '{8'hA5, 20'd40000,   8'd100, 20'd40100,   20'd39900};
        vt[1] = '{8'h01, 20'd40000,   8'd100, 20'd40100,   20'd39900};
        vt[2] = '{8'hFF, 20'd40000,   8'd100, 20'd40100,   20'd39900};
        vt[3] = '{8'h5A, 20'hFFFF0,   8'd255, 20'hFFFFF,   20'hFFEF1};
        vt[4] = '{8'hC3, 20'd50,      8'd255, 20'd305,     20'd0};
        vt[5] = '{8'h7E, 20'd40000,   8'd0,   20'd40000,   20'd40000};
        vt[6] = '{8'h80, 20'd1000,    8'd1,   20'd1001,    20'd999};

        // Reset and idle: data_go low keeps the pending byte out.
        nrst = 0; data_go = 0; tx_valid = 1; tx_data = 8'h55;
        freq_base = 20'd40000; freq_dev = 8'd100;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_freq", freq, 20'd40000);
        chk("rst_busy", tx_busy, 0);
        nrst = 1;
        for (int i = 0; i < 3; i++) tick();
        chk("idle_ready", tx_ready, 0);
        chk("idle_busy", tx_busy, 0);
        chk("idle_freq", freq, 20'd40000);
        tx_valid = 0;

        // Table of frames: each bit period must carry the mark or space word.
        for (int k = 0; k < 7; k++) begin
            freq_base = vt[k].base; freq_dev = vt[k].dev; data_go = 1;
            tick();
            run_frame(vt[k].b, 0, -1, -1);
            for (int n = 0; n < 11; n++)
                chk($sformatf("vec%0d_bit%0d", k, n), got[n],
                    frame_bit(vt[k].b, n) ? vt[k].mark : vt[k].space);
            chk($sformatf("vec%0d_idle_freq", k), freq, vt[k].base);
            chk($sformatf("vec%0d_idle_busy", k), tx_busy, 0);
        end

        // Back-to-back with tx_valid held: exactly one idle cycle between frames.
        freq_base = 20'd40000; freq_dev = 8'd100; data_go = 1;
        tick();
        run_frame(8'h01, 1, -1, -1);
        chk("b2b_par01", got[9], 20'd40100);
        chk("b2b_gap_busy", tx_busy, 0);
        chk("b2b_gap_ready", tx_ready, 1);
        chk("b2b_gap_freq", freq, 20'd40000);
        run_frame(8'hFF, 0, -1, -1);
        chk("b2b_parFF", got[9], 20'd39900);

        // Mid-frame data_go drop and base change during data bit 3.
        tick();
        run_frame(8'h3C, 0, 17, -1);
        chk("mid_start", got[0], 20'd39900);
        chk("mid_bit4", got[5], 20'd40100);
        chk("mid_stop", got[10], 20'd40100);
        chk("mid_after_freq", freq, 20'd30000);
        chk("mid_after_ready", tx_ready, 0);
        tx_valid = 1;
        for (int i = 0; i < 3; i++) tick();
        chk("mid_no_accept", tx_busy, 0);
        tx_valid = 0;

        // Reset pulse during the parity bit abandons the frame.
        freq_base = 20'd40000; data_go = 1;
        tick();
        run_frame(8'h96, 0, -1, 38);
        chk("rstmid_freq", freq, RF);
        chk("rstmid_busy", tx_busy, 0);
        dcnt = 0;
        data_go = 0;
        for (int i = 0; i < 50; i++) begin
            if (frame_done === 1'b1) dcnt++;
            tick();
        end
        chk("rstmid_no_done", dcnt, 0);
        data_go = 1;
        run_frame(8'h5A, 0, -1, -1);
        for (int n = 0; n < 11; n++)
            chk($sformatf("rstmid_new_bit%0d", n), got[n],
                frame_bit(8'h5A, n) ? 20'd40100 : 20'd39900);

        // Randomized traffic, checked cycle by cycle by the model.
        for (int i = 0; i < 1500; i++) begin
            nrst     = ($urandom_range(0, 199) != 0);
            data_go  = ($urandom_range(0, 3) != 0);
            tx_valid = $urandom_range(0, 1);
            tx_data  = 8'($urandom);
            if ($urandom_range(0, 15) == 0)
                freq_base = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(20'hFFF00, 20'hFFFFF))
                                                        : 20'($urandom_range(0, 20'hFFFFF));
            if ($urandom_range(0, 15) == 0)
                freq_dev = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/swipt_fsk_tx.md
# swipt_fsk_tx

- FSK data transmitter for the SWIPT link.
- Once the optimization loop raises `data_go`, it takes bytes through a valid/ready handshake and frames each one as start, 8 data, even parity and stop.
- It shifts the carrier frequency word driven into SwiptOut up (mark) or down (space) around the optimized base frequency for each bit period.
- It sits between the optimization logic, which owns `freq_base`, and SwiptOut. The receiver on the far side of the analog network demodulates the frequency shifts.

## Interface

**Parameters**
- `FREQ_W`, 20: width of frequency words, in Hz.
- `BIT_CYCLES`, 10000: clocks per bit (8 carrier periods at 40 kHz, 50 MHz clk).
- `CNT_W`, 14: width of the bit-period counter; must hold `BIT_CYCLES-1`.
- `RESET_FREQ`, 20'h9C40: `freq` value driven during and straight after reset (40 000 Hz).

**Ports**
- `clk`, in, 1: system clock.
- `nrst`, in, 1: synchronous, active-low reset.
- `data_go`, in, 1: transfer enable from the optimization loop.
- `freq_base`, in, FREQ_W: optimized carrier frequency.
- `freq_dev`, in, 8: FSK deviation in Hz.
- `tx_data`, in, 8: byte to send.
- `tx_valid`, in, 1: `tx_data` is valid.
- `tx_ready`, out, 1: block can accept a byte this cycle.
- `freq`, out, FREQ_W: frequency word to SwiptOut; registered.
- `tx_busy`, out, 1: a frame is in progress.
- `frame_done`, out, 1: one-cycle pulse in the final cycle of the stop bit.

## Operation

**States**
- IDLE
- START
- DATA (bit index 0..7)
- PARITY
- STOP

**IDLE**
- `freq` <= `freq_base` every cycle (unmodulated carrier, so power transfer continues).
- `tx_ready` = `data_go` (combinational, IDLE only).
- On `tx_valid && tx_ready`:
  - latch `tx_data` into the shift register;
  - compute even parity (XOR of the 8 bits);
  - latch `freq_base` and `freq_dev`;
  - go to START.

**Bit encoding** (uses the latched values; changes to `freq_base`/`freq_dev` mid-frame are ignored)
- Mark (1): `freq` = base + dev, saturating at 2^FREQ_W-1. Compute at FREQ_W+1 bits, then clamp.
- Space (0): `freq` = base - dev, saturating at 0.
- Bit values per state:
  - START = space.
  - DATA = `tx_data` LSB first.
  - PARITY = parity bit (1 when the byte has an odd number of ones).
  - STOP = mark.

**Bit timing**
- Each state lasts exactly `BIT_CYCLES` clocks.
- The counter runs 0..`BIT_CYCLES`-1 and wraps to 0 on every bit transition.
- The DATA bit index advances on each wrap. On wrap at index 7, go to PARITY.

**Frame end**
- STOP wraps to IDLE.
- `frame_done` = 1 in the last cycle of STOP.
- `tx_busy` = 1 in every state except IDLE.

**Boundary cases**
- `data_go` falling mid-frame: the frame always completes; no truncation. No further byte is accepted until `data_go` returns high.
- `tx_valid` while busy: ignored, and `tx_ready` = 0. The byte stays pending at the source until the next IDLE cycle.
- `freq_dev` = 0: mark = space = base. Framing still runs normally.
- Reset (`nrst` = 0 at a clk edge), including mid-frame: the frame is abandoned with no `frame_done`. The next cycle has:
  - state IDLE;
  - counter 0, bit index 0, shift register 0;
  - `freq` = `RESET_FREQ`;
  - `tx_busy` = 0, `frame_done` = 0.
- `tx_ready` is 0 while `nrst` = 0.

## Timing

- Handshake sampled at edge k.
- `freq` shows the start-bit space value from cycle k+1. START occupies cycles k+1 .. k+`BIT_CYCLES`.
- Bit n (start = 0, data = 1..8, parity = 9, stop = 10) occupies cycles k+1+n·`BIT_CYCLES` .. k+(n+1)·`BIT_CYCLES`.
- `frame_done` is high in cycle k+11·`BIT_CYCLES`.
- IDLE at k+11·`BIT_CYCLES`+1:
  - `freq` = `freq_base` sampled at the previous edge;
  - `tx_ready` is high if `data_go`.
- Minimum gap between back-to-back frames is exactly one cycle at the base frequency.
- `tx_busy` rises at k+1 and falls at k+11·`BIT_CYCLES`+1.
- In IDLE, `freq` follows `freq_base` with one cycle of latency.

## Test plan

All scenarios use `BIT_CYCLES` = 4, `freq_base` = 40000, `freq_dev` = 100.

1. **Reset and idle.**
   - Stimulus: hold reset 5 cycles, then `nrst` = 1 with `data_go` = 0 and `tx_valid` = 1.
   - Response: `freq` = 40000 (= 0x9C40), `tx_ready` = 0, `tx_busy` = 0, nothing sent.
2. **Single frame.**
   - Stimulus: `data_go` = 1, send `tx_data` = 8'hA5.
   - Response (4 cycles per bit): `freq` = 39900, then 40100/39900/40100/39900/39900/40100/39900/40100 (LSB first), parity 39900 (even count), stop 40100.
   - `frame_done` is high exactly at cycle k+44; `freq` = 40000 at k+45.
3. **Back-to-back frames.**
   - Stimulus: `tx_valid` held high with bytes 8'h01 then 8'hFF.
   - Response: second acceptance at k+45, exactly one IDLE cycle; the 8'hFF frame has parity bit 39900.
4. **Mid-frame input changes.**
   - Stimulus: drop `data_go` and change `freq_base` to 30000 during DATA bit 3.
   - Response: the frame finishes on the original 40000 ± 100 values. Afterwards `freq` = 30000 and `tx_ready` = 0.
5. **Saturation.**
   - Stimulus: `freq_base` = 20'hFFFF0 with `freq_dev` = 255, then `freq_base` = 50 with `freq_dev` = 255.
   - Response: mark = 20'hFFFFF; space = 0.
6. **Reset mid-frame.**
   - Stimulus: `nrst` = 0 for 1 cycle during PARITY.
   - Response: the next cycle shows `freq` = 40000, `tx_busy` = 0; `frame_done` never pulses.
   - A new byte is accepted cleanly once `nrst` = 1.
